// File: rtl/etchnet_pkg.sv
// rtl/etchnet_pkg.sv - shared types and helpers for the serializer datapath
package etchnet_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit counter width: ceil(log2(w)), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter, MSB first, one-word skid hold
module bit_serializer
    import etchnet_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             out_valid,
    output logic             out_first
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             load;

    assign in_ready = ~hold_valid;
    assign accept   = in_valid & ~hold_valid;
    // hold drains into the shifter when idle or on the last bit of the current word
    assign load     = hold_valid & ((state == IDLE) | (cnt == LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (accept) begin
                hold       <= in_data;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        shreg <= hold;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        cnt   <= cnt + CW'(1);
                    end else if (hold_valid) begin
                        shreg <= hold;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == SHIFT);
    assign out_first = (state == SHIFT) && (cnt == '0);
    assign data_out  = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per parallel word; legal range 2..64.
REQ-002 SHALL have parameter IDLE_BIT, default 0: value driven on data_out when no word is being shifted.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-008 SHALL have port data_out, output, 1: serial bit stream; feeds the single-bit data input of the downstream tap shifter.
REQ-009 SHALL have port out_valid, output, 1: data_out carries a payload bit this cycle.
REQ-010 SHALL have port out_first, output, 1: data_out carries the first (MSB) bit of a word this cycle.

Function
REQ-011 SHALL accept a word on any rising edge where in_valid and in_ready are both 1; no other edge transfers data.
REQ-012 SHALL contain a one-word holding register (hold, hold_valid), a WIDTH-bit shift register, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 SHALL drive in_ready = NOT hold_valid, with no combinational path from in_valid.
REQ-014 SHALL write every accepted word into hold and set hold_valid.
REQ-015 SHALL implement a two-state FSM: IDLE (out_valid=0) and SHIFT (out_valid=1).
REQ-016 IDLE -> SHIFT SHALL occur on the first edge with hold_valid=1: load the shift register from hold, clear hold_valid, set counter to 0.
REQ-017 In SHIFT, data_out SHALL equal the shift-register MSB; words are sent MSB first, one bit per cycle.
REQ-018 In SHIFT with counter < WIDTH-1, each edge SHALL shift the register left by one and increment the counter.
REQ-019 In SHIFT with counter = WIDTH-1 and hold_valid=1, the edge SHALL reload from hold, clear hold_valid, zero the counter and stay in SHIFT, so words stream with no gap.
REQ-020 In SHIFT with counter = WIDTH-1 and hold_valid=0, the edge SHALL return to IDLE.
REQ-021 If an accept and a load from hold fall on the same edge, the load SHALL take the old hold contents; the new word SHALL occupy hold and hold_valid SHALL stay 1.
REQ-022 out_first SHALL be 1 exactly when in SHIFT with counter = 0.
REQ-023 In IDLE, data_out SHALL equal IDLE_BIT and out_first SHALL be 0.
REQ-024 Latency: a word accepted on edge k while IDLE with hold empty SHALL present its MSB in the cycle after edge k+1 and its LSB WIDTH-1 cycles later.
REQ-025 Throughput: under continuous in_valid, the output SHALL have out_valid=1 every cycle after the first word, at 1 bit/cycle.
REQ-026 While in_ready=0, the upstream holds in_data stable; the block SHALL NOT sample in_data.
REQ-027 data_out, out_valid and out_first SHALL be decoded from registered state only (no input-to-output combinational path).

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counter 0, shift register 0, hold 0, hold_valid 0.
REQ-029 During reset, outputs SHALL be: data_out = IDLE_BIT, out_valid = 0, out_first = 0, in_ready = 1.
REQ-030 Reset asserted mid-word SHALL discard the partial word and any held word; no bits of either SHALL appear after release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 The FSM state enum (IDLE, SHIFT) SHALL live in the shared package etchnet_pkg.
REQ-033 The counter-width helper function SHALL live in the shared package etchnet_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the hold register is inline.

Verification (WIDTH=8, IDLE_BIT=0)
REQ-035 Single word: 0xA5 accepted on edge k -> data_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; out_first=1 only in cycle k+1; out_valid=0 from cycle k+9.
REQ-036 Back-to-back: 0xFF, 0x00, 0x81 with in_valid held high -> 24 contiguous out_valid cycles carrying the bits of FF, 00, 81 in order; out_first at bit offsets 0, 8 and 16.
REQ-037 Backpressure: offer a third word while hold is full -> in_ready=0 and the word is not taken; it is accepted on the first edge after in_ready returns to 1 and streams without loss.
REQ-038 Reset mid-word: rst_n low after 3 bits of 0xF0 -> out_valid=0, data_out=0 and in_ready=1 immediately; after release, no further bits of 0xF0 appear.
REQ-039 Chain with downstream tap shifter (shift1=3, shift2=7): stream 0x80 -> a single 1 appears at out1 three cycles and at out2 seven cycles after the cycle where bit 7 is on data_out.
